// File: rtl/shr_seq_pkg.sv
// Shared definitions for the sequential right shifter: state encoding and default width.
package shr_seq_pkg;

  localparam int DEFAULT_DATAWIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shr_seq.sv
// Multi-cycle right shifter: one bit per clock, logical or arithmetic fill,
// shift amounts at or above the width saturate to a full shift-out.
module shr_seq
  import shr_seq_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic                 arith,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] sh_amt,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] d
);

  localparam int CW = $clog2(DATAWIDTH + 1);
  localparam logic [CW-1:0]      CNT_MAX = CW'(DATAWIDTH);
  localparam logic [DATAWIDTH:0] SAT_LIM = (DATAWIDTH + 1)'(DATAWIDTH);

  state_e                 state, state_nxt;
  logic [DATAWIDTH-1:0]   work;
  logic [CW-1:0]          count;
  logic                   fill;
  logic                   saturate;

  // The saturation test uses every bit of sh_amt, so large amounts whose low
  // bits happen to look small are still treated as a full shift-out.
  assign saturate = ({1'b0, sh_amt} >= SAT_LIM);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next-state is assigned a default before the case so no path through
  // this combinational block leaves it unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (count == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      work  <= '0;
      count <= '0;
      fill  <= 1'b0;
      d     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            work  <= a;
            fill  <= arith & a[DATAWIDTH-1];
            count <= saturate ? CNT_MAX : sh_amt[CW-1:0];
          end
        end
        SHIFT: begin
          if (count != '0) begin
            work  <= DATAWIDTH'({fill, work} >> 1);
            count <= count - 1'b1;
          end else begin
            d <= work;
          end
        end
        default: ;
      endcase
    end
  end

  // The final SHIFT cycle only transfers the result, so a zero-amount
  // request never shows busy.
  assign busy = (state == SHIFT) && (count != '0);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shr_seq.sv
// Directed self-checking bench for shr_seq with hand-computed results and latencies.
module tb_shr_seq;

  localparam int DW = 8;

  logic          Clk;
  logic          Rst;
  logic          start;
  logic          arith;
  logic [DW-1:0] a;
  logic [DW-1:0] sh_amt;
  logic          busy;
  logic          done;
  logic [DW-1:0] d;

  int checks   = 0;
  int failures = 0;

  shr_seq #(.DATAWIDTH(DW)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .start  (start),
    .arith  (arith),
    .a      (a),
    .sh_amt (sh_amt),
    .busy   (busy),
    .done   (done),
    .d      (d)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One complete operation; inputs are scrambled right after capture so any
  // late sampling of a, sh_amt or arith corrupts the result.
  task automatic run_op(input string name, input logic [DW-1:0] ta,
                        input logic [DW-1:0] tsh, input logic tar,
                        input logic [DW-1:0] exp_d, input int exp_lat);
    int   lat;
    logic got_done;
    logic busy_seen;
    logic overlap;
    logic [DW-1:0] d_at_done;
    @(posedge Clk); #1;
    start = 1'b1; a = ta; sh_amt = tsh; arith = tar;
    @(posedge Clk); #1;
    start = 1'b0; a = ~ta; sh_amt = 8'd1; arith = ~tar;
    lat = 0; got_done = 1'b0; busy_seen = 1'b0; overlap = 1'b0; d_at_done = '0;
    if (busy) busy_seen = 1'b1;
    for (int i = 0; i < 20 && !got_done; i++) begin
      @(posedge Clk); #1;
      lat++;
      if (busy) busy_seen = 1'b1;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        got_done  = 1'b1;
        d_at_done = d;
      end
    end
    checks++;
    if (!got_done) begin
      failures++;
      $display("FAIL %s_timeout: done never rose within 20 cycles (expected after %0d)", name, exp_lat);
    end else begin
      checks++;
      if (d_at_done !== exp_d) begin
        failures++;
        $display("FAIL %s_d: got 0x%02h expected 0x%02h", name, d_at_done, exp_d);
      end
      checks++;
      if (lat !== exp_lat) begin
        failures++;
        $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
      end
    end
    checks++;
    if (busy_seen !== (exp_lat > 1)) begin
      failures++;
      $display("FAIL %s_busy_seen: got %0b expected %0b", name, busy_seen, exp_lat > 1);
    end
    checks++;
    if (overlap !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_done_overlap: got 1 expected 0", name);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; start = 1'b0; arith = 1'b0; a = '0; sh_amt = '0;
    #2;
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL reset_d: got 0x%02h expected 0x00", d); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
    @(posedge Clk); #2;
    Rst = 1'b0;
  endtask

  task automatic test_logical();
    run_op("logical_20_1", 8'd20, 8'd1, 1'b0, 8'd10, 2);
    run_op("logical_a0_3", 8'hA0, 8'd3, 1'b0, 8'h14, 4);
    run_op("logical_80_7", 8'h80, 8'd7, 1'b0, 8'h01, 8);
  endtask

  task automatic test_arith();
    run_op("arith_a0_3", 8'hA0, 8'd3, 1'b1, 8'hF4, 4);
    run_op("arith_80_7", 8'h80, 8'd7, 1'b1, 8'hFF, 8);
    run_op("arith_pos_60_2", 8'h60, 8'd2, 1'b1, 8'h18, 3);
  endtask

  task automatic test_zero_shift();
    run_op("zero_40", 8'd40, 8'd0, 1'b0, 8'd40, 1);
    run_op("zero_arith_c3", 8'hC3, 8'd0, 1'b1, 8'hC3, 1);
  endtask

  task automatic test_saturate();
    run_op("sat_arith_200", 8'h80, 8'd200, 1'b1, 8'hFF, 9);
    run_op("sat_logic_200", 8'h80, 8'd200, 1'b0, 8'h00, 9);
    run_op("sat_arith_8", 8'h80, 8'd8, 1'b1, 8'hFF, 9);
    run_op("sat_logic_16", 8'hFF, 8'd16, 1'b0, 8'h00, 9);
  endtask

  task automatic test_start_ignored();
    int pulses;
    int lat;
    logic [DW-1:0] d_at_done;
    @(posedge Clk); #1;
    start = 1'b1; a = 8'd20; sh_amt = 8'd4; arith = 1'b0;
    @(posedge Clk); #1;
    start = 1'b0;
    pulses = 0; lat = 0; d_at_done = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge Clk); #1;
      if (cyc == 2) begin start = 1'b1; a = 8'hFF; sh_amt = 8'd1; end
      if (cyc == 3) start = 1'b0;
      if (done) begin
        pulses++;
        if (pulses == 1) begin lat = cyc; d_at_done = d; end
      end
    end
    checks++;
    if (pulses !== 1) begin failures++; $display("FAIL ignored_pulses: got %0d expected 1", pulses); end
    checks++;
    if (d_at_done !== 8'd1) begin failures++; $display("FAIL ignored_d: got 0x%02h expected 0x01", d_at_done); end
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL ignored_latency: got %0d expected 5", lat); end
  endtask

  task automatic test_reset_mid();
    logic done_seen;
    @(posedge Clk); #1;
    start = 1'b1; a = 8'hF0; sh_amt = 8'd6; arith = 1'b0;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (2) @(posedge Clk);
    #3;
    Rst = 1'b1;
    #1;
    checks++;
    if (d !== 8'h00) begin failures++; $display("FAIL midrst_d: got 0x%02h expected 0x00", d); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
    @(posedge Clk); #2;
    Rst = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      if (done) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0) begin failures++; $display("FAIL midrst_no_done: got 1 expected 0"); end
    run_op("after_rst_20_3", 8'd20, 8'd3, 1'b0, 8'd2, 4);
  endtask

  initial begin
    test_reset();
    test_logical();
    test_arith();
    test_zero_shift();
    test_saturate();
    test_start_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
